// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants: active-low a..g patterns (bit6=a) and special BCD codes.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

endpackage

// File: rtl/seven_seg_to_bcd.sv
// Inverse segment decode: active-low pattern to BCD code plus illegal-pattern flag.
// Latency: combinational. Backpressure: none.
module seven_seg_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = CODE_ERR;
        err  = 1'b1;
        case (seg)
            SEG_0:     begin code = 4'd0;       err = 1'b0; end
            SEG_1:     begin code = 4'd1;       err = 1'b0; end
            SEG_2:     begin code = 4'd2;       err = 1'b0; end
            SEG_3:     begin code = 4'd3;       err = 1'b0; end
            SEG_4:     begin code = 4'd4;       err = 1'b0; end
            SEG_5:     begin code = 4'd5;       err = 1'b0; end
            SEG_6:     begin code = 4'd6;       err = 1'b0; end
            SEG_7:     begin code = 4'd7;       err = 1'b0; end
            SEG_8:     begin code = 4'd8;       err = 1'b0; end
            SEG_9:     begin code = 4'd9;       err = 1'b0; end
            SEG_BLANK: begin code = CODE_BLANK; err = 1'b0; end
            default:   begin code = CODE_ERR;   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Passive reader of a multiplexed seven-segment bus; publishes frames after STABLE_CNT repeats.
// Latency: frame_valid/bcd_out update 1 clk after the edge sampling the final digit.
// Backpressure: none; a passive observer, published frames are not handshaked.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_CNT     = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic [6:0]              seg_n,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    locked
);

    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      SETTLE_LD = 8'(SETTLE_CYCLES);
    localparam logic [3:0]      MATCH_MAX = 4'(STABLE_CNT);
    localparam logic [TW-1:0]   TO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

    logic [NUM_DIGITS-1:0]   an_s1, an_s2, an_prev;
    logic [6:0]              seg_s1, seg_s2;
    logic [7:0]              settle_cnt;
    logic                    armed;
    logic [NUM_DIGITS-1:0]   seen;
    logic [4*NUM_DIGITS-1:0] buf_code, prev_code;
    logic [NUM_DIGITS-1:0]   buf_err, prev_err;
    logic                    frame_done;
    logic [3:0]              match_cnt;
    logic [TW-1:0]           to_cnt;

    logic [NUM_DIGITS-1:0]   sel;
    logic                    legal, change, sample, complete, frame_eq;
    logic [3:0]              dec_code, match_nxt;
    logic                    dec_err;

    seven_seg_to_bcd u_dec (
        .seg  (seg_s2),
        .code (dec_code),
        .err  (dec_err)
    );

    // A sample is taken once per legal anode value, after it has held for the settle window.
    always_comb begin
        sel      = ~an_s2;
        legal    = $onehot(sel);
        change   = (an_s2 != an_prev);
        sample   = legal && !change && armed && (settle_cnt == 8'd0);
        complete = sample && ((seen | sel) == ALL_SEEN);
        frame_eq = (buf_code == prev_code) && (buf_err == prev_err);
        if (match_cnt != 4'd0 && frame_eq)
            match_nxt = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + 4'd1;
        else
            match_nxt = 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1       <= '1;
            an_s2       <= '1;
            an_prev     <= '1;
            seg_s1      <= '1;
            seg_s2      <= '1;
            settle_cnt  <= 8'd0;
            armed       <= 1'b0;
            seen        <= '0;
            buf_code    <= '1;
            buf_err     <= '0;
            prev_code   <= '1;
            prev_err    <= '0;
            frame_done  <= 1'b0;
            match_cnt   <= 4'd0;
            to_cnt      <= '0;
            bcd_out     <= '1;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
        end else begin
            an_s1       <= an_n;
            an_s2       <= an_s1;
            an_prev     <= an_s2;
            seg_s1      <= seg_n;
            seg_s2      <= seg_s1;
            frame_valid <= 1'b0;
            frame_done  <= complete;

            if (!legal) begin
                settle_cnt <= SETTLE_LD;
                armed      <= 1'b0;
            end else if (change) begin
                settle_cnt <= SETTLE_LD;
                armed      <= 1'b1;
            end else if (armed) begin
                if (settle_cnt == 8'd0)
                    armed <= 1'b0;
                else
                    settle_cnt <= settle_cnt - 8'd1;
            end

            if (sample) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        buf_code[4*i +: 4] <= dec_code;
                        buf_err[i]         <= dec_err;
                    end
                end
                seen <= complete ? '0 : (seen | sel);
            end

            // Buffer already holds the completed frame; compare it with the previous one.
            if (frame_done) begin
                prev_code <= buf_code;
                prev_err  <= buf_err;
                match_cnt <= match_nxt;
                if (match_nxt == MATCH_MAX) begin
                    bcd_out     <= buf_code;
                    digit_err   <= buf_err;
                    frame_valid <= 1'b1;
                    locked      <= 1'b1;
                end else begin
                    locked <= 1'b0;
                end
            end

            if (sample) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_LAST) begin
                    seen      <= '0;
                    match_cnt <= 4'd0;
                    locked    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: scans digit patterns and checks published frames.
module tb_seven_seg_capture;

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PX = 7'b1010101;
    // Raw drive of the final digit to frame_valid: 2 sync + 1 detect + 4 settle + 1 sample + 1 publish.
    localparam int LAT = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        locked;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int fv_cyc   = 0;
    int drv_cyc  = 0;
    int base;

    seven_seg_capture #(
        .NUM_DIGITS     (4),
        .SETTLE_CYCLES  (4),
        .STABLE_CNT     (3),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .bcd_out     (bcd_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            pulses <= pulses + 1;
            fv_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full scan, digit 0 first; each anode held for dwell clocks.
    task automatic show_frame(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3, input int dwell);
        logic [6:0] pat [4];
        logic [3:0] one;
        one    = 4'b0001;
        pat[0] = p0;
        pat[1] = p1;
        pat[2] = p2;
        pat[3] = p3;
        for (int i = 0; i < 4; i++) begin
            an_n  = ~(one << i);
            seg_n = pat[i];
            if (i == 3) drv_cyc = cyc;
            repeat (dwell) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        an_n  = 4'b1111;
        seg_n = PB;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle lines after reset
        repeat (100) @(negedge clk);
        check("idle_bcd", 32'(bcd_out), 32'h0000FFFF);
        check("idle_err", 32'(digit_err), 32'h0);
        check("idle_locked", 32'(locked), 32'h0);
        check("idle_pulses", 32'(pulses), 32'h0);

        // Stable 4321 scan: only the third frame publishes
        show_frame(P1, P2, P3, P4, 20);
        show_frame(P1, P2, P3, P4, 20);
        check("lock_early", 32'(pulses), 32'h0);
        show_frame(P1, P2, P3, P4, 20);
        check("lock_pulses", 32'(pulses), 32'h1);
        check("lock_latency", 32'(fv_cyc - drv_cyc), 32'(LAT));
        check("lock_bcd", 32'(bcd_out), 32'h00004321);
        check("lock_err", 32'(digit_err), 32'h0);
        check("lock_locked", 32'(locked), 32'h1);
        show_frame(P1, P2, P3, P4, 20);
        check("fourth_pulses", 32'(pulses), 32'h2);
        check("fourth_bcd", 32'(bcd_out), 32'h00004321);

        // Digit 2 changes to 7: lock lost, value held until 3 new frames agree
        show_frame(P1, P2, P7, P4, 20);
        check("chg_pulses", 32'(pulses), 32'h2);
        check("chg_locked", 32'(locked), 32'h0);
        check("chg_bcd_hold", 32'(bcd_out), 32'h00004321);
        show_frame(P1, P2, P7, P4, 20);
        check("chg2_pulses", 32'(pulses), 32'h2);
        show_frame(P1, P2, P7, P4, 20);
        check("chg3_pulses", 32'(pulses), 32'h3);
        check("chg3_bcd", 32'(bcd_out), 32'h00004721);
        check("chg3_locked", 32'(locked), 32'h1);

        // Blank digit 1 and illegal pattern on digit 3
        repeat (3) show_frame(P1, PB, P3, PX, 20);
        check("err_bcd", 32'(bcd_out), 32'h0000E3F1);
        check("err_flags", 32'(digit_err), 32'h8);
        check("err_locked", 32'(locked), 32'h1);

        // Short dwells and multi-low glitches take no samples
        base = pulses;
        show_frame(P5, P6, P7, P8, 5);
        show_frame(P5, P6, P7, P8, 5);
        for (int k = 0; k < 4; k++) begin
            an_n  = 4'b1100;
            seg_n = P8;
            repeat (3) @(negedge clk);
            an_n  = 4'b1110;
            repeat (4) @(negedge clk);
        end
        an_n = 4'b1100;
        repeat (10) @(negedge clk);
        check("short_pulses", 32'(pulses), 32'(base));
        check("short_locked", 32'(locked), 32'h1);
        check("short_bcd", 32'(bcd_out), 32'h0000E3F1);
        repeat (1000) @(negedge clk);
        check("timeout_locked", 32'(locked), 32'h0);
        check("timeout_bcd", 32'(bcd_out), 32'h0000E3F1);
        check("timeout_err", 32'(digit_err), 32'h8);
        check("timeout_pulses", 32'(pulses), 32'(base));

        // Reset with two digits of a frame captured
        an_n  = 4'b1110;
        seg_n = P8;
        repeat (20) @(negedge clk);
        an_n  = 4'b1101;
        seg_n = P9;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        an_n  = 4'b1111;
        #1;
        check("rst_bcd", 32'(bcd_out), 32'h0000FFFF);
        check("rst_err", 32'(digit_err), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        base = pulses;
        show_frame(P8, P9, P0, P5, 20);
        show_frame(P8, P9, P0, P5, 20);
        check("post_rst_pulses", 32'(pulses), 32'(base));
        check("post_rst_bcd", 32'(bcd_out), 32'h0000FFFF);
        show_frame(P8, P9, P0, P5, 20);
        check("relock_pulses", 32'(pulses), 32'(base + 1));
        check("relock_latency", 32'(fv_cyc - drv_cyc), 32'(LAT));
        check("relock_bcd", 32'(bcd_out), 32'h00005098);
        check("relock_locked", 32'(locked), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
